// File: rtl/cpu_control_fsm.sv
// Moore control FSM for the simple RISC core: fetch, PC update, decode, execute.
// Optional halt state with a halted output: define CTRL_HALT_EN.
module cpu_control_fsm #(
   parameter int STATE_W = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   output logic [2:0] nsel,
   output logic [1:0] vsel,
   output logic       write,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic       load_ir,
   output logic       load_pc,
   output logic       reset_pc,
   output logic       addr_sel,
   output logic       load_addr,
   output logic [1:0] mem_cmd
`ifdef CTRL_HALT_EN
   ,
   output logic       halted
`endif
);

   typedef enum logic [STATE_W-1:0] {
      S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
      S_WIMM, S_GETA, S_GETB, S_GETD, S_ALU,
      S_CMP, S_WRD, S_ADDR, S_LADDR, S_PASS,
      S_MRD1, S_MRD2, S_MWR, S_HALT
   } state_t;

   localparam logic [1:0] MC_IDLE  = 2'b00;
   localparam logic [1:0] MC_READ  = 2'b10;
   localparam logic [1:0] MC_WRITE = 2'b01;

   localparam logic [4:0] I_MOVI = 5'b110_10;
   localparam logic [4:0] I_MOVR = 5'b110_00;
   localparam logic [4:0] I_ADD  = 5'b101_00;
   localparam logic [4:0] I_AND  = 5'b101_10;
   localparam logic [4:0] I_CMP  = 5'b101_01;
   localparam logic [4:0] I_MVN  = 5'b101_11;
   localparam logic [4:0] I_LDR  = 5'b011_00;
   localparam logic [4:0] I_STR  = 5'b100_00;

   state_t     state_q, state_d;
   // decoded instruction captured in S_DEC steers the shared execute states
   logic [4:0] ins_q, ins_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_RST;
         ins_q   <= '0;
      end else begin
         state_q <= state_d;
         ins_q   <= ins_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ins_d     = ins_q;
      nsel      = 3'b000;
      vsel      = 2'b00;
      write     = 1'b0;
      loada     = 1'b0;
      loadb     = 1'b0;
      loadc     = 1'b0;
      loads     = 1'b0;
      asel      = 1'b0;
      bsel      = 1'b0;
      load_ir   = 1'b0;
      load_pc   = 1'b0;
      reset_pc  = 1'b0;
      addr_sel  = 1'b0;
      load_addr = 1'b0;
      mem_cmd   = MC_IDLE;
`ifdef CTRL_HALT_EN
      halted    = 1'b0;
`endif
      unique case (state_q)
         S_IF1: begin
            addr_sel = 1'b1;
            mem_cmd  = MC_READ;
            state_d  = S_IF2;
         end
         S_IF2: begin
            addr_sel = 1'b1;
            mem_cmd  = MC_READ;
            load_ir  = 1'b1;
            state_d  = S_UPC;
         end
         S_UPC: begin
            load_pc = 1'b1;
            state_d = S_DEC;
         end
         S_DEC: begin
            ins_d = {opcode, op};
            case ({opcode, op})
               I_MOVI:         state_d = S_WIMM;
               I_MOVR, I_MVN:  state_d = S_GETB;
               I_ADD, I_AND,
               I_CMP:          state_d = S_GETA;
               I_LDR, I_STR:   state_d = S_GETA;
               default:        state_d = S_IF1;
            endcase
`ifdef CTRL_HALT_EN
            if (opcode == 3'b111) state_d = S_HALT;
`endif
         end
         S_WIMM: begin
            nsel    = 3'b001;
            vsel    = 2'b10;
            write   = 1'b1;
            state_d = S_IF1;
         end
         S_GETA: begin
            nsel  = 3'b101;
            loada = 1'b1;
            if (ins_q == I_LDR || ins_q == I_STR)
               state_d = S_ADDR;
            else
               state_d = S_GETB;
         end
         S_GETB: begin
            nsel    = 3'b010;
            loadb   = 1'b1;
            state_d = (ins_q == I_CMP) ? S_CMP : S_ALU;
         end
         S_GETD: begin
            nsel    = 3'b110;
            loadb   = 1'b1;
            state_d = S_PASS;
         end
         S_ALU: begin
            loadc   = 1'b1;
            asel    = (ins_q == I_MOVR);
            state_d = S_WRD;
         end
         S_CMP: begin
            loads   = 1'b1;
            state_d = S_IF1;
         end
         S_WRD: begin
            nsel    = 3'b100;
            write   = 1'b1;
            state_d = S_IF1;
         end
         S_ADDR: begin
            bsel    = 1'b1;
            loadc   = 1'b1;
            state_d = S_LADDR;
         end
         S_LADDR: begin
            load_addr = 1'b1;
            state_d   = (ins_q == I_STR) ? S_GETD : S_MRD1;
         end
         S_PASS: begin
            asel    = 1'b1;
            loadc   = 1'b1;
            state_d = S_MWR;
         end
         S_MRD1: begin
            mem_cmd = MC_READ;
            state_d = S_MRD2;
         end
         S_MRD2: begin
            mem_cmd = MC_READ;
            nsel    = 3'b100;
            vsel    = 2'b11;
            write   = 1'b1;
            state_d = S_IF1;
         end
         S_MWR: begin
            mem_cmd = MC_WRITE;
            state_d = S_IF1;
         end
`ifdef CTRL_HALT_EN
         S_HALT: begin
            halted  = 1'b1;
            state_d = S_HALT;
         end
`endif
         default: begin
            reset_pc = 1'b1;
            load_pc  = 1'b1;
            state_d  = S_IF1;
         end
      endcase
   end

endmodule
